register_universal: RTL and testbench

- Parametrised successor to the single-bit master-slave D register cell.
- Stores a WIDTH-bit word and provides these operations in one block, selected per cycle by Mode:
  - hold
  - parallel load
  - shift left and shift right with serial input
  - increment and decrement
  - synchronous clear
- Serves as the general-purpose working register of the register library, replacing ad-hoc banks of single-bit cells.
- Keeps the library's inverted-data-input convention (notD) and dual-rail outputs (Q, notQ).

---
 rtl/register_universal_pkg.sv | 22 ++
 rtl/register_universal_bit.sv | 55 +++++
 rtl/register_universal.sv | 78 +++++++
 tb/tb_register_universal.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_universal_pkg.sv
// Shared operation codes and width limits for the universal working register.
// Imported by the bit slice and the top level.
package register_universal_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_INC  = 3'b100;
    localparam logic [2:0] MODE_DEC  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // True when the requested operation can change state; reserved code acts as hold.
    function automatic logic mode_active(input logic en, input logic [2:0] mode);
        return en && (mode != MODE_HOLD) && (mode != MODE_RSVD);
    endfunction

endpackage

// File: rtl/register_universal_bit.sv
// One bit of the universal register: next-state mux, half-adder/subtractor slice
// and an async-reset storage cell with dual-rail outputs.
module register_universal_bit
    import register_universal_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       d,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       carry_in,
    output logic       carry_out,
    output logic       q,
    output logic       q_n
);

    logic q_r;
    logic next_bit;
    logic sum_bit;

    // Increment and decrement share the sum bit; only the carry/borrow term differs.
    assign sum_bit   = q_r ^ carry_in;
    assign carry_out = (mode == MODE_DEC) ? (~q_r & carry_in) : (q_r & carry_in);

    always_comb begin
        next_bit = q_r;
        if (en) begin
            case (mode)
                MODE_LOAD: next_bit = d;
                MODE_SHL:  next_bit = shl_in;
                MODE_SHR:  next_bit = shr_in;
                MODE_INC:  next_bit = sum_bit;
                MODE_DEC:  next_bit = sum_bit;
                MODE_CLR:  next_bit = 1'b0;
                default:   next_bit = q_r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RESET_BIT;
        end else begin
            q_r <= next_bit;
        end
    end

    assign q   = q_r;
    assign q_n = ~q_r;

endmodule

// File: rtl/register_universal.sv
// Parametrised general-purpose working register: hold, load (inverted data),
// shifts with serial input, increment/decrement with carry flag, and clear.
module register_universal
    import register_universal_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             notRst,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] notD,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic             Co
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] load_word;
    logic             co_r;

    assign load_word = ~notD;
    // Incrementing/decrementing by one: the chain starts with a carry/borrow of 1 at the LSB.
    assign carry[0]  = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shl_in;
        logic shr_in;

        if (i == 0) begin : g_lsb
            assign shl_in = SerIn;
        end else begin : g_mid_l
            assign shl_in = Q[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign shr_in = SerIn;
        end else begin : g_mid_r
            assign shr_in = Q[i+1];
        end

        register_universal_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk       (Clk),
            .rst_n     (notRst),
            .en        (En),
            .mode      (Mode),
            .d         (load_word[i]),
            .shl_in    (shl_in),
            .shr_in    (shr_in),
            .carry_in  (carry[i]),
            .carry_out (carry[i+1]),
            .q         (Q[i]),
            .q_n       (notQ[i])
        );
    end

    // Co only moves on operations that change the word; hold, reserved and En=0 keep it.
    always_ff @(posedge Clk or negedge notRst) begin
        if (!notRst) begin
            co_r <= 1'b0;
        end else if (mode_active(En, Mode)) begin
            case (Mode)
                MODE_SHL: co_r <= Q[WIDTH-1];
                MODE_SHR: co_r <= Q[0];
                MODE_INC: co_r <= carry[WIDTH];
                MODE_DEC: co_r <= carry[WIDTH];
                default:  co_r <= 1'b0;
            endcase
        end
    end

    assign Co = co_r;

endmodule

// File: tb/tb_register_universal.sv
// Directed bench for register_universal across widths 2/8/16/32 with a
// behavioural reference model feeding an expected-result queue.
module tb_register_universal;
    import register_universal_pkg::*;

    localparam int N = 5;

    logic        Clk = 1'b0;
    logic        notRst;
    logic        en_v   [N];
    logic [2:0]  mode_v [N];
    logic [31:0] notd_v [N];
    logic        ser_v  [N];
    logic        co_v   [N];

    logic [7:0]  q0, nq0, q1, nq1;
    logic [1:0]  q2, nq2;
    logic [15:0] q3, nq3;
    logic [31:0] q4, nq4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] q;
        logic        co;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_q  [N];
    logic        m_co [N];

    always #5 Clk = ~Clk;

    register_universal #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_a (
        .Clk(Clk), .notRst(notRst), .En(en_v[0]), .Mode(mode_v[0]), .notD(notd_v[0][7:0]),
        .SerIn(ser_v[0]), .Q(q0), .notQ(nq0), .Co(co_v[0]));
    register_universal #(.WIDTH(8), .RESET_VALUE(8'h0F)) u_b (
        .Clk(Clk), .notRst(notRst), .En(en_v[1]), .Mode(mode_v[1]), .notD(notd_v[1][7:0]),
        .SerIn(ser_v[1]), .Q(q1), .notQ(nq1), .Co(co_v[1]));
    register_universal #(.WIDTH(2), .RESET_VALUE(2'b01)) u_w2 (
        .Clk(Clk), .notRst(notRst), .En(en_v[2]), .Mode(mode_v[2]), .notD(notd_v[2][1:0]),
        .SerIn(ser_v[2]), .Q(q2), .notQ(nq2), .Co(co_v[2]));
    register_universal #(.WIDTH(16), .RESET_VALUE(16'h1234)) u_w16 (
        .Clk(Clk), .notRst(notRst), .En(en_v[3]), .Mode(mode_v[3]), .notD(notd_v[3][15:0]),
        .SerIn(ser_v[3]), .Q(q3), .notQ(nq3), .Co(co_v[3]));
    register_universal #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u_w32 (
        .Clk(Clk), .notRst(notRst), .En(en_v[4]), .Mode(mode_v[4]), .notD(notd_v[4]),
        .SerIn(ser_v[4]), .Q(q4), .notQ(nq4), .Co(co_v[4]));

    function automatic int wid(int i);
        case (i)
            0, 1:    return 8;
            2:       return 2;
            3:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] rstv(int i);
        case (i)
            0:       return 32'hA5;
            1:       return 32'h0F;
            2:       return 32'h1;
            3:       return 32'h1234;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic logic [31:0] wmask(int i);
        return (wid(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(i)) - 32'd1);
    endfunction

    function automatic logic [31:0] get_q(int i);
        case (i)
            0:       return {24'd0, q0};
            1:       return {24'd0, q1};
            2:       return {30'd0, q2};
            3:       return {16'd0, q3};
            default: return q4;
        endcase
    endfunction

    function automatic logic [31:0] get_nq(int i);
        case (i)
            0:       return {24'd0, nq0};
            1:       return {24'd0, nq1};
            2:       return {30'd0, nq2};
            3:       return {16'd0, nq3};
            default: return nq4;
        endcase
    endfunction

    // Reference model: returns {co, q} after one edge.
    function automatic logic [32:0] mnext(int i, logic [31:0] q, logic co, logic en,
                                          logic [2:0] mode, logic [31:0] nd, logic ser);
        logic [31:0] m;
        int          w;
        m = wmask(i);
        w = wid(i);
        if (!en) return {co, q};
        case (mode)
            MODE_LOAD: return {1'b0, ~nd & m};
            MODE_SHL:  return {q[w-1], ((q << 1) | {31'd0, ser}) & m};
            MODE_SHR:  return {q[0], (q >> 1) | ({31'd0, ser} << (w - 1))};
            MODE_INC:  return {q == m, (q + 32'd1) & m};
            MODE_DEC:  return {q == 32'd0, (q - 32'd1) & m};
            MODE_CLR:  return {1'b0, 32'd0};
            default:   return {co, q};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_now(int i, logic [31:0] q, logic co, string tag);
        chk({tag, " q"}, get_q(i), q);
        chk({tag, " notq"}, get_nq(i), ~q & wmask(i));
        chk({tag, " co"}, {31'd0, co_v[i]}, {31'd0, co});
    endtask

    task automatic op(int i, logic en, logic [2:0] mode, logic [31:0] nd, logic ser, string tag);
        exp_t        e;
        logic [32:0] nx;
        @(negedge Clk);
        for (int k = 0; k < N; k++) en_v[k] = 1'b0;
        en_v[i]   = en;
        mode_v[i] = mode;
        notd_v[i] = nd;
        ser_v[i]  = ser;
        nx = mnext(i, m_q[i], m_co[i], en, mode, nd, ser);
        m_q[i]  = nx[31:0];
        m_co[i] = nx[32];
        sb.push_back('{i, nx[31:0], nx[32], tag});
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, " q"}, get_q(e.idx), e.q);
        chk({e.tag, " notq"}, get_nq(e.idx), ~e.q & wmask(e.idx));
        chk({e.tag, " co"}, {31'd0, co_v[e.idx]}, {31'd0, e.co});
    endtask

    // Drop reset mid-cycle (optionally while one register is incrementing) and check it acts at once.
    task automatic reset_pulse(int active, string tag);
        @(negedge Clk);
        for (int k = 0; k < N; k++) en_v[k] = 1'b0;
        if (active >= 0) begin
            en_v[active]   = 1'b1;
            mode_v[active] = MODE_INC;
        end
        #2;
        notRst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            m_q[k]  = rstv(k);
            m_co[k] = 1'b0;
            chk_now(k, rstv(k), 1'b0, tag);
        end
        @(posedge Clk);
        #1;
        for (int k = 0; k < N; k++) chk_now(k, rstv(k), 1'b0, {tag, " held"});
        @(negedge Clk);
        for (int k = 0; k < N; k++) en_v[k] = 1'b0;
        #1;
        notRst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        notRst = 1'b1;
        for (int k = 0; k < N; k++) begin
            en_v[k]   = 1'b0;
            mode_v[k] = MODE_HOLD;
            notd_v[k] = 32'd0;
            ser_v[k]  = 1'b0;
        end

        // Reset before any clock edge.
        #3;
        notRst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            m_q[k]  = rstv(k);
            m_co[k] = 1'b0;
        end
        chk_now(0, 32'hA5, 1'b0, "reset_a");
        chk("reset_a notq raw", {24'd0, nq0}, 32'h5A);
        @(negedge Clk);
        #1;
        notRst = 1'b1;

        op(0, 1'b1, MODE_HOLD, 32'h00, 1'b1, "hold_after_reset");
        chk_now(0, 32'hA5, 1'b0, "hold_a5");

        // Load and hold.
        op(0, 1'b1, MODE_LOAD, 32'hC3, 1'b1, "load_c3");
        chk_now(0, 32'h3C, 1'b0, "load_3c");
        for (int n = 0; n < 3; n++) op(0, 1'b0, MODE_INC, 32'h00, 1'b0, "en0_inc");
        chk_now(0, 32'h3C, 1'b0, "en0_held");

        // Shifts.
        op(0, 1'b1, MODE_LOAD, 32'h7E, 1'b0, "load_81");
        op(0, 1'b1, MODE_SHL, 32'h00, 1'b0, "shl");
        chk_now(0, 32'h02, 1'b1, "shl_02");
        op(0, 1'b1, MODE_SHR, 32'h00, 1'b1, "shr");
        chk_now(0, 32'h81, 1'b0, "shr_81");
        op(0, 1'b1, MODE_SHR, 32'h00, 1'b0, "shr_out1");

        // Wrap-around on INC/DEC, Co stickiness.
        op(0, 1'b1, MODE_LOAD, 32'h01, 1'b0, "load_fe");
        op(0, 1'b1, MODE_INC, 32'h00, 1'b1, "inc_ff");
        chk_now(0, 32'hFF, 1'b0, "inc_ff_c");
        op(0, 1'b1, MODE_INC, 32'h00, 1'b1, "inc_wrap");
        chk_now(0, 32'h00, 1'b1, "inc_wrap_c");
        op(0, 1'b1, MODE_DEC, 32'h00, 1'b1, "dec_wrap");
        chk_now(0, 32'hFF, 1'b1, "dec_wrap_c");
        op(0, 1'b1, MODE_HOLD, 32'h00, 1'b0, "hold_co");
        op(0, 1'b1, MODE_RSVD, 32'h00, 1'b1, "rsvd_co");
        chk_now(0, 32'hFF, 1'b1, "co_sticky");
        op(0, 1'b1, MODE_LOAD, 32'h00, 1'b0, "load_clears_co");
        chk_now(0, 32'hFF, 1'b0, "load_co0");
        op(0, 1'b1, MODE_DEC, 32'h00, 1'b0, "dec_no_borrow");

        reset_pulse(-1, "reset_mid");
        chk_now(0, 32'hA5, 1'b0, "reset_mid_a5");

        // CLR goes to zero, not to the reset value; reserved code holds.
        op(1, 1'b1, MODE_LOAD, 32'h88, 1'b0, "b_load_77");
        op(1, 1'b1, MODE_RSVD, 32'h00, 1'b1, "b_rsvd_77");
        chk_now(1, 32'h77, 1'b0, "b_rsvd_held");
        op(1, 1'b1, MODE_CLR, 32'h00, 1'b1, "b_clr");
        chk_now(1, 32'h00, 1'b0, "b_clr_00");
        op(1, 1'b1, MODE_RSVD, 32'h55, 1'b1, "b_rsvd_00");

        // WIDTH=2 full count: one Co pulse per wrap.
        op(2, 1'b1, MODE_LOAD, 32'h3, 1'b0, "w2_load0");
        for (int n = 0; n < 9; n++) op(2, 1'b1, MODE_INC, 32'h0, n[0], "w2_inc");
        op(2, 1'b1, MODE_SHL, 32'h0, 1'b1, "w2_shl");
        op(2, 1'b1, MODE_DEC, 32'h0, 1'b0, "w2_dec");

        // WIDTH=16 near the boundary.
        op(3, 1'b1, MODE_LOAD, 32'h0002, 1'b0, "w16_load_fffd");
        for (int n = 0; n < 4; n++) op(3, 1'b1, MODE_INC, 32'h0, 1'b0, "w16_inc");
        for (int n = 0; n < 2; n++) op(3, 1'b1, MODE_DEC, 32'h0, 1'b1, "w16_dec");
        op(3, 1'b1, MODE_SHR, 32'h0, 1'b1, "w16_shr");

        // WIDTH=32 near the boundary, then reset during an increment.
        op(4, 1'b1, MODE_LOAD, 32'h1, 1'b0, "w32_load_fffffffe");
        for (int n = 0; n < 3; n++) op(4, 1'b1, MODE_INC, 32'h0, 1'b0, "w32_inc");
        op(4, 1'b1, MODE_SHL, 32'h0, 1'b1, "w32_shl");
        reset_pulse(4, "reset_during_inc");
        chk_now(4, 32'hDEADBEEF, 1'b0, "w32_reset_value");
        op(4, 1'b1, MODE_INC, 32'h0, 1'b0, "w32_inc_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
